// File: rtl/div_updown_pkg.sv
// Shared defaults and helpers for the divided up/down counter.
package div_updown_pkg;

   localparam int unsigned DEF_WIDTH   = 4;
   localparam int unsigned DEF_DIV_W   = 3;
   localparam int unsigned DEF_RST_VAL = 0;

   // Largest value representable in w bits.
   function automatic int unsigned max_val(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/clk_en_div.sv
// Programmable clock-enable divider: raises step every div_sel+1 enabled cycles.
module clk_en_div
   import div_updown_pkg::*;
#(
   parameter int unsigned DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div_sel,
   input  logic             clr,
   output logic             step
);

   logic [DIV_W-1:0] div_cnt;

   // A compare rather than equality means a lowered div_sel fires at once.
   assign step = en && (div_cnt >= div_sel);

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (clr || step) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/div_updown_counter.sv
// Up/down counter advanced by a divided clock enable, with wrap/saturate and sticky overflow.
module div_updown_counter
   import div_updown_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned DIV_W   = DEF_DIV_W,
   parameter int unsigned RST_VAL = DEF_RST_VAL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div_sel,
   input  logic             dir,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));

   logic             step;
   logic             at_lim;
   logic [WIDTH-1:0] nxt;

   clk_en_div #(
      .DIV_W (DIV_W)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .div_sel (div_sel),
      .clr     (load),
      .step    (step)
   );

   // Limit in the current direction; doubles as terminal count.
   assign at_lim = dir ? (count == MAX) : (count == '0);
   assign tc     = at_lim;

   always_comb begin
      nxt = count;
      if (at_lim) begin
         if (!sat) begin
            nxt = dir ? '0 : MAX;
         end
      end else begin
         nxt = dir ? count + WIDTH'(1) : count - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= WIDTH'(RST_VAL);
         tick  <= 1'b0;
         ovf   <= 1'b0;
      end else if (load) begin
         count <= load_val;
         tick  <= 1'b0;
         if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end else begin
         tick <= step;
         // A boundary step wins over a simultaneous clear.
         ovf  <= (ovf && !ovf_clr) || (step && at_lim);
         if (step) begin
            count <= nxt;
         end
      end
   end

endmodule

// File: doc/div_updown_counter.md
DIV_UPDOWN_COUNTER -- requirements
Module: div_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (>=2).
REQ-002 Parameter DIV_W, default 3, width of divide-select input (>=1).
REQ-003 Parameter RST_VAL, default 0, count value loaded at reset (< 2**WIDTH).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  enable; 0 freezes divider and counter.
REQ-007 div_sel  input  DIV_W  divide select; count step every div_sel+1 enabled cycles.
REQ-008 dir  input  1  1 = count up, 0 = count down.
REQ-009 sat  input  1  1 = saturate at limits, 0 = wrap.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  value for load.
REQ-012 ovf_clr  input  1  clears sticky ovf.
REQ-013 count  output  WIDTH  registered counter value.
REQ-014 tick  output  1  registered one-cycle pulse marking each count step.
REQ-015 tc  output  1  terminal count, combinational from count and dir.
REQ-016 ovf  output  1  sticky overflow/underflow flag.

Function
REQ-017 Divider: internal div_cnt (DIV_W bits) increments each cycle with en=1; step condition = en && div_cnt >= div_sel; on step div_cnt SHALL return to 0.
REQ-018 div_sel=0 SHALL give a step every enabled cycle; div_sel lowered below current div_cnt SHALL give a step on the next enabled cycle (no long wrap).
REQ-019 en=0: div_cnt, count, ovf hold; tick SHALL be 0 in the following cycle.
REQ-020 On step, dir=1: count+1; at 2**WIDTH-1, count SHALL become 0 (sat=0) or hold 2**WIDTH-1 (sat=1).
REQ-021 On step, dir=0: count-1; at 0, count SHALL become 2**WIDTH-1 (sat=0) or hold 0 (sat=1).
REQ-022 Boundary step per REQ-020/021 SHALL set ovf in both wrap and saturate modes; dir and sat sampled on the step edge.
REQ-023 tick SHALL be 1 for exactly the cycle in which count first shows the stepped value (including saturated hold); latency step condition -> tick = 1 clk.
REQ-024 load=1 SHALL override step and en: count<=load_val, div_cnt<=0, tick<=0, ovf unchanged.
REQ-025 tc SHALL equal (dir && count==2**WIDTH-1) || (!dir && count==0).
REQ-026 ovf_clr=1 clears ovf next edge; simultaneous set and clear SHALL leave ovf=1.
REQ-027 No derived or gated clock SHALL be produced; tick is a clock enable only.

Reset
REQ-028 rst=0 at a rising edge SHALL force count=RST_VAL, div_cnt=0, tick=0, ovf=0, overriding load and all inputs.
REQ-029 Reset asserted mid-count SHALL discard divider progress; first step after release occurs div_sel+1 enabled cycles later.

Structure
REQ-030 Package div_updown_pkg SHALL hold default parameter constants and the localparam function for MAX value (2**WIDTH-1).
REQ-031 Divider SHALL be a sub-module clk_en_div (clk, rst, en, div_sel, clr, step) instantiated once; clr driven by load.
REQ-032 Counter/ovf/tick logic SHALL reside in div_updown_counter; estimated 150-250 RTL lines total.

Verification (WIDTH=4, DIV_W=3, RST_VAL=0)
REQ-033 Reset then en=1, div_sel=2, dir=1, sat=0 for 48 cycles -> count 0,1,...,15,0 stepping every 3 cycles; tick 16 pulses; ovf=1 after 15->0.
REQ-034 load_val=2, load pulse, dir=0, sat=1, div_sel=0 -> count 2,1,0,0,0; tc=1 at 0; ovf=1; tick still pulses on saturated holds.
REQ-035 div_sel=7, en toggled 0 for 5 cycles mid-period -> step delayed exactly 5 cycles; no tick while en=0.
REQ-036 div_sel changed 7->1 when div_cnt=5 -> step on next enabled cycle, then every 2 cycles.
REQ-037 ovf=1, ovf_clr=1 on same edge as 15->0 wrap -> ovf stays 1; next ovf_clr alone -> ovf=0.
REQ-038 rst=0 asserted with load=1, count=9 -> count=0, tick=0, ovf=0 next edge; first step div_sel+1 cycles after release.
